// File: rtl/mix_engine.sv
// mix_engine: iterative N-lane, W-bit state mixer. One mixing stage runs per
// clock. A run of `iters` blocks is launched from IDLE, reported by busy while
// running, and finished by a single-cycle done pulse.
//
// Handshake: load and start are level-sampled on the rising clock edge and
// are acted on only while the engine is in IDLE. A start in RUN or FIN is
// dropped, not queued. The engine has no ready output. The caller treats a
// sampled start as accepted whenever the engine was idle at that edge.
module mix_engine #(
    parameter int W      = 32,
    parameter int N      = 8,
    parameter int ROUNDS = 3,
    parameter int IW     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [$clog2(N)-1:0] seed_lane,
    input  logic [W-1:0]         seed_data,
    input  logic                 start,
    input  logic [IW-1:0]        iters,
    input  logic [$clog2(N)-1:0] rd_lane,
    output logic [W-1:0]         rd_data,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state_o
);

    localparam int LW = $clog2(N);
    localparam int S  = 5 + 2 * ROUNDS;
    localparam int SW = $clog2(S);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [2:0] OP_P0   = 3'd0;
    localparam logic [2:0] OP_P1   = 3'd1;
    localparam logic [2:0] OP_MIX  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_SHR  = 3'd4;
    localparam logic [2:0] OP_FOLD = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;

    logic [W-1:0]  x_q [N];
    logic [W-1:0]  x_d [N];
    logic [W-1:0]  mix_v [N];
    logic [1:0]    state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [IW-1:0] block_q, block_d;
    logic [IW-1:0] iters_q, iters_d;
    logic [2:0]    op;

    // Map the stage counter onto an operation. The MIX/XOR pairs fill stages
    // 2 .. S-4, with MIX on the even stages. With ROUNDS=0 that range is empty.
    always_comb begin
        if (stage_q == SW'(0))          op = OP_P0;
        else if (stage_q == SW'(1))     op = OP_P1;
        else if (stage_q == SW'(S - 3)) op = OP_SHR;
        else if (stage_q == SW'(S - 2)) op = OP_FOLD;
        else if (stage_q == SW'(S - 1)) op = OP_MUL;
        else if (stage_q[0] == 1'b0)    op = OP_MIX;
        else                            op = OP_XOR;
    end

    // In-place lane chain: lane i reads lanes < i already updated this stage
    // and lanes >= i still holding their registered values.
    always_comb begin
        for (int i = 0; i < N; i++) mix_v[i] = x_q[i];
        for (int i = 0; i < N; i++) begin
            case (op)
                OP_P0:   mix_v[i] = mix_v[i] + W'(i);
                OP_P1:   mix_v[i] = mix_v[i] + mix_v[LW'((i + N - 1) % N)];
                OP_MIX:  mix_v[i] = mix_v[i] + mix_v[LW'((i + 1) % N)]
                                    - mix_v[LW'((i + N - 3) % N)];
                OP_XOR:  mix_v[i] = mix_v[i] ^ (mix_v[LW'((i + 3) % N)] << (W / 2));
                OP_SHR:  mix_v[i] = mix_v[i] - (mix_v[LW'((i + 2) % N)] >> (W / 2 + 1))
                                    + (mix_v[LW'((i + 4) % N)] >> (3 * W / 8));
                OP_FOLD: mix_v[i] = mix_v[i] + mix_v[LW'((i + N - 1) % N)]
                                    - mix_v[LW'((i + N - 2) % N)];
                OP_MUL:  mix_v[i] = mix_v[i] * W'(2 * i + 3) + W'(i);
                default: mix_v[i] = mix_v[i];
            endcase
        end
    end

    // Next-state logic: seeding and launch in IDLE, stage/block stepping in
    // RUN, a single pass through FIN back to IDLE.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        block_d = block_q;
        iters_d = iters_q;
        for (int i = 0; i < N; i++) x_d[i] = x_q[i];
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    for (int i = 0; i < N; i++) begin
                        if (seed_lane == LW'(i)) x_d[i] = seed_data;
                    end
                end
                if (start) begin
                    iters_d = iters;
                    stage_d = '0;
                    block_d = '0;
                    state_d = (iters == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < N; i++) x_d[i] = mix_v[i];
                if (stage_q == SW'(S - 1)) begin
                    stage_d = '0;
                    block_d = block_q + IW'(1);
                    if (block_q + IW'(1) == iters_q) state_d = ST_FIN;
                end else begin
                    stage_d = stage_q + SW'(1);
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers. Reset abandons any run and restores x[i] = i.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) x_q[i] <= W'(i);
            state_q <= ST_IDLE;
            stage_q <= '0;
            block_q <= '0;
            iters_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) x_q[i] <= x_d[i];
            state_q <= state_d;
            stage_q <= stage_d;
            block_q <= block_d;
            iters_q <= iters_d;
        end
    end

    // Lane read mux, built as a match loop so it also works when N is not a
    // power of two.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_lane == LW'(i)) rd_data = x_q[i];
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_FIN);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mix_engine.sv
// Bench for mix_engine: a default instance (W=32, N=8, ROUNDS=3) and a small
// instance (W=8, N=4, ROUNDS=0), checked against an arithmetic lane model.
`timescale 1ns/1ps
module tb_mix_engine;

  typedef longint unsigned u64;

  localparam int OP_P0 = 0, OP_P1 = 1, OP_MIX = 2, OP_XOR = 3,
                 OP_SHR = 4, OP_FOLD = 5, OP_MUL = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance signals
  logic        a_load = 0, a_start = 0;
  logic [2:0]  a_seed_lane = 0, a_rd_lane = 0;
  logic [31:0] a_seed_data = 0;
  logic [15:0] a_iters = 0;
  logic [31:0] a_rd_data;
  logic        a_busy, a_done;
  logic [1:0]  a_dbg;

  // small instance signals
  logic        b_load = 0, b_start = 0;
  logic [1:0]  b_seed_lane = 0, b_rd_lane = 0;
  logic [7:0]  b_seed_data = 0;
  logic [15:0] b_iters = 0;
  logic [7:0]  b_rd_data;
  logic        b_busy, b_done;
  logic [1:0]  b_dbg;

  mix_engine dut_a (
    .clk(clk), .rst_n(rst_n), .load(a_load), .seed_lane(a_seed_lane),
    .seed_data(a_seed_data), .start(a_start), .iters(a_iters),
    .rd_lane(a_rd_lane), .rd_data(a_rd_data), .busy(a_busy), .done(a_done),
    .dbg_state_o(a_dbg)
  );

  mix_engine #(.W(8), .N(4), .ROUNDS(0), .IW(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(b_load), .seed_lane(b_seed_lane),
    .seed_data(b_seed_data), .start(b_start), .iters(b_iters),
    .rd_lane(b_rd_lane), .rd_data(b_rd_data), .busy(b_busy), .done(b_done),
    .dbg_state_o(b_dbg)
  );

  // ---------------- scoreboard ----------------
  int vec_cnt = 0;
  int miss_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  u64 m[8];
  int mn, mw, mr;

  function automatic u64 msk(input u64 v);
    return v & ((64'd1 << mw) - 64'd1);
  endfunction

  function automatic void model_stage(input int op);
    for (int i = 0; i < mn; i++) begin
      u64 a;
      a = m[i];
      case (op)
        OP_P0:   a = a + u64'(i);
        OP_P1:   a = a + m[(i + mn - 1) % mn];
        OP_MIX:  a = a + m[(i + 1) % mn] - m[(i + mn - 3) % mn];
        OP_XOR:  a = a ^ (m[(i + 3) % mn] << (mw / 2));
        OP_SHR:  a = a - (m[(i + 2) % mn] >> (mw / 2 + 1)) + (m[(i + 4) % mn] >> (3 * mw / 8));
        OP_FOLD: a = a + m[(i + mn - 1) % mn] - m[(i + mn - 2) % mn];
        OP_MUL:  a = a * u64'(2 * i + 3) + u64'(i);
        default: a = a;
      endcase
      m[i] = msk(a);
    end
  endfunction

  function automatic void model_blocks(input int k);
    int seq[$];
    seq = {};
    seq.push_back(OP_P0);
    seq.push_back(OP_P1);
    for (int r = 0; r < mr; r++) begin
      seq.push_back(OP_MIX);
      seq.push_back(OP_XOR);
    end
    seq.push_back(OP_SHR);
    seq.push_back(OP_FOLD);
    seq.push_back(OP_MUL);
    for (int b = 0; b < k; b++)
      foreach (seq[s]) model_stage(seq[s]);
  endfunction

  function automatic void push_model();
    for (int i = 0; i < mn; i++) exp_q.push_back(32'(m[i]));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic a_load_lane(input int lane, input logic [31:0] d);
    @(negedge clk);
    a_load = 1'b1; a_seed_lane = 3'(lane); a_seed_data = d;
    @(negedge clk);
    a_load = 1'b0;
  endtask

  task automatic b_load_lane(input int lane, input logic [7:0] d);
    @(negedge clk);
    b_load = 1'b1; b_seed_lane = 2'(lane); b_seed_data = d;
    @(negedge clk);
    b_load = 1'b0;
  endtask

  task automatic a_start_run(input int k);
    @(negedge clk);
    a_start = 1'b1; a_iters = 16'(k);
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic b_start_run(input int k);
    @(negedge clk);
    b_start = 1'b1; b_iters = 16'(k);
    @(negedge clk);
    b_start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle, or after the budget expires.
  task automatic a_wait_done(output int bc, output bit dn);
    bc = 0; dn = 0;
    for (int c = 0; c < 2000; c++) begin
      if (a_done) begin dn = 1; break; end
      if (a_busy) bc++;
      @(negedge clk);
    end
  endtask

  task automatic b_wait_done(output int bc, output bit dn);
    bc = 0; dn = 0;
    for (int c = 0; c < 2000; c++) begin
      if (b_done) begin dn = 1; break; end
      if (b_busy) bc++;
      @(negedge clk);
    end
  endtask

  task automatic a_check_lanes(input string nm);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_rd_lane = 3'(i);
      #1;
      check($sformatf("%s lane%0d", nm, i), a_rd_data, exp_q.pop_front());
    end
  endtask

  task automatic b_check_lanes(input string nm);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_rd_lane = 2'(i);
      #1;
      check($sformatf("%s lane%0d", nm, i), {24'd0, b_rd_data}, exp_q.pop_front());
    end
  endtask

  task automatic a_seed_all(input logic [31:0] sd[8]);
    for (int i = 0; i < 8; i++) a_load_lane(i, sd[i]);
    mn = 8; mw = 32; mr = 3;
    for (int i = 0; i < 8; i++) m[i] = u64'(sd[i]);
  endtask

  function automatic void model_from_reset_a();
    mn = 8; mw = 32; mr = 3;
    for (int i = 0; i < 8; i++) m[i] = u64'(i);
  endfunction

  // ---------------- vector table for the small instance ----------------
  typedef struct packed {
    logic [3:0][7:0] seed;
    logic [15:0]     iters;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t tbl[5];
  localparam int S_A = 5 + 2 * 3;
  localparam int S_B = 5;

  // watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int bc, bc2;
    bit dn, dn2;
    int it_list[5];
    logic [31:0] sd[8];

    // Fill the table: row 0 is the hand-worked known answer, the rest come
    // from the model with random seeds.
    it_list = '{1, 2, 3, 1, 4};
    tbl[0].seed = '0;
    tbl[0].iters = 16'd1;
    tbl[0].exp[0] = 8'd21; tbl[0].exp[1] = 8'd6;
    tbl[0].exp[2] = 8'd2;  tbl[0].exp[3] = 8'd84;
    for (int r = 1; r < 5; r++) begin
      mn = 4; mw = 8; mr = 0;
      for (int i = 0; i < 4; i++) begin
        tbl[r].seed[i] = 8'($urandom_range(0, 255));
        m[i] = u64'(tbl[r].seed[i]);
      end
      tbl[r].iters = 16'(it_list[r]);
      model_blocks(it_list[r]);
      for (int i = 0; i < 4; i++) tbl[r].exp[i] = 8'(m[i]);
    end

    do_reset();

    // Reset state
    @(negedge clk);
    check("reset busy", {31'd0, a_busy}, 32'd0);
    check("reset done", {31'd0, a_done}, 32'd0);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
    a_check_lanes("reset");
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
    b_check_lanes("reset_b");

    // Zero iterations
    a_start_run(0);
    a_wait_done(bc, dn);
    check("zero_iter done", {31'd0, dn}, 32'd1);
    check("zero_iter busy cycles", 32'(bc), 32'd0);
    @(negedge clk);
    check("zero_iter done width", {31'd0, a_done}, 32'd0);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
    a_check_lanes("zero_iter");

    // Table-driven runs on the small instance
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) b_load_lane(i, tbl[r].seed[i]);
      b_start_run(int'(tbl[r].iters));
      b_wait_done(bc, dn);
      check($sformatf("tbl%0d done", r), {31'd0, dn}, 32'd1);
      check($sformatf("tbl%0d busy cycles", r), 32'(bc), 32'(int'(tbl[r].iters) * S_B));
      @(negedge clk);
      check($sformatf("tbl%0d done width", r), {31'd0, b_done}, 32'd0);
      for (int i = 0; i < 4; i++) exp_q.push_back({24'd0, tbl[r].exp[i]});
      b_check_lanes($sformatf("tbl%0d", r));
    end

    // Timing with start/load pulsed mid-run (both must be ignored)
    for (int i = 0; i < 8; i++) sd[i] = $urandom;
    a_seed_all(sd);
    model_blocks(3);
    a_start_run(3);
    bc = 0; dn = 0;
    for (int c = 0; c < 2000; c++) begin
      if (a_done) begin dn = 1; break; end
      if (a_busy) bc++;
      if (c == 10 || c == 20) begin
        a_start = 1'b1; a_iters = 16'd7;
        a_load = 1'b1; a_seed_lane = 3'(c % 8); a_seed_data = 32'hFFFF0000;
      end else begin
        a_start = 1'b0; a_load = 1'b0;
      end
      @(negedge clk);
    end
    a_start = 1'b0; a_load = 1'b0;
    check("timing done", {31'd0, dn}, 32'd1);
    check("timing busy cycles", 32'(bc), 32'(3 * S_A));
    @(negedge clk);
    check("timing no rerun", {31'd0, a_busy | a_done}, 32'd0);
    push_model();
    a_check_lanes("timing");

    // Reset mid-run at stage 4 of block 2
    for (int i = 0; i < 8; i++) sd[i] = $urandom;
    a_seed_all(sd);
    a_start_run(3);
    bc = 0; dn = 0;
    for (int c = 0; c < 2000; c++) begin
      if (a_done) dn = 1;
      if (a_busy) bc++;
      if (bc == 2 * S_A + 4 + 1) break;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset busy", {31'd0, a_busy}, 32'd0);
    check("midreset done", {31'd0, a_done}, 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (a_done) dn = 1;
      @(negedge clk);
    end
    check("midreset no done pulse", {31'd0, dn}, 32'd0);
    model_from_reset_a();
    push_model();
    a_check_lanes("midreset");
    model_blocks(2);
    a_start_run(2);
    a_wait_done(bc, dn);
    check("post_reset run done", {31'd0, dn}, 32'd1);
    push_model();
    a_check_lanes("post_reset run");

    // Load and start in the same cycle
    do_reset();
    model_from_reset_a();
    m[2] = 64'hDEADBEEF;
    model_blocks(1);
    @(negedge clk);
    a_load = 1'b1; a_seed_lane = 3'd2; a_seed_data = 32'hDEADBEEF;
    a_start = 1'b1; a_iters = 16'd1;
    @(negedge clk);
    a_load = 1'b0; a_start = 1'b0;
    a_wait_done(bc, dn);
    check("simul done", {31'd0, dn}, 32'd1);
    check("simul busy cycles", 32'(bc), 32'(S_A));
    push_model();
    a_check_lanes("simul");

    // Random seeds, back-to-back runs
    for (int t = 0; t < 4; t++) begin
      int k1, k2;
      k1 = $urandom_range(1, 3);
      k2 = $urandom_range(1, 3);
      for (int i = 0; i < 8; i++) sd[i] = $urandom;
      a_seed_all(sd);
      model_blocks(k1 + k2);
      a_start_run(k1);
      a_wait_done(bc, dn);
      a_start_run(k2);
      a_wait_done(bc2, dn2);
      check($sformatf("rand%0d done", t), {30'd0, dn, dn2}, 32'd3);
      check($sformatf("rand%0d busy cycles", t), 32'(bc + bc2), 32'((k1 + k2) * S_A));
      push_model();
      a_check_lanes($sformatf("rand%0d", t));
    end

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/mix_engine.md
Name: mix_engine

Overview:
- Parametrised iterative state-mixing engine: N lanes of W-bit state, scrambled by a fixed stage sequence.
- Generalises the fixed 8×32-bit per-clock mixer into a start/busy/done block with a configurable lane count, width, round count and iteration count.
- Executes one mixing stage per clock.
- Used as a deterministic, compute-heavy load generator and as a checksum source in the simulation suites.

Parameters:
- W, 32: lane width in bits; must be ≥ 8 and a multiple of 8.
- N, 8: lane count; must be ≥ 4.
- ROUNDS, 3: number of MIX/XOR round pairs per block; may be 0.
- IW, 16: width of the iteration-count input.

Ports:
- clk  in  1  clock; all state updates on the posedge.
- rst_n  in  1  synchronous active-low reset.
- load  in  1  write seed_data into lane seed_lane; honoured only in IDLE.
- seed_lane  in  clog2(N)  lane index for load.
- seed_data  in  W  seed value.
- start  in  1  begin running iters blocks; honoured only in IDLE.
- iters  in  IW  number of blocks to run; sampled when start is accepted.
- rd_lane  in  clog2(N)  lane to read.
- rd_data  out  W  combinational read of x[rd_lane]; valid in any state.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset (rst_n=0 at a posedge, in any state, including mid-run):
  - x[i] = i.
  - FSM goes to IDLE; stage counter and block counter are cleared.
  - busy = 0, done = 0.
  - A run in progress is abandoned; no done pulse is issued.
- Arithmetic:
  - All arithmetic is modulo 2^W. Shifts are logical.
  - Lane indices are taken mod N.
  - Within a stage, lanes update in order i = 0..N-1 with in-place semantics: lane i sees the already-updated values of lanes < i. This is a combinational chain; its result is registered at the end of the cycle.
- Stage sequence per block (S = 5 + 2·ROUNDS stages, one per clock):
  - P0: x[i] = x[i] + i.
  - P1: x[i] = x[i] + x[i-1].
  - Then ROUNDS repetitions of the MIX/XOR pair:
    - MIX: x[i] = x[i] + x[i+1] − x[i+N−3].
    - XOR: x[i] = x[i] ^ (x[i+3] << W/2).
  - SHR: x[i] = x[i] − (x[i+2] >> (W/2+1)) + (x[i+4] >> (3W/8)).
  - FOLD: x[i] = x[i] + x[i-1] − x[i-2].
  - MUL: x[i] = x[i]·(2i+3) + i.
- FSM states: IDLE, RUN, FIN.
  - IDLE:
    - load writes x[seed_lane] = seed_data.
    - start latches iters. If iters=0, go to FIN; otherwise go to RUN with stage=0, block=0.
    - load and start in the same cycle: the load is applied, and RUN starts from the loaded state.
  - RUN:
    - Each cycle executes the current stage, then advances stage.
    - After MUL: block increments. If block == iters, go to FIN; otherwise stage returns to P0.
  - FIN: done = 1 for exactly this cycle, busy = 0, then return to IDLE.
- Inputs ignored outside IDLE:
  - start is ignored in RUN and FIN; it is not queued.
  - load is ignored in RUN and FIN; the state is not modified.
- Latency:
  - start accepted at cycle t (iters = k > 0).
  - busy is high for cycles t+1 .. t+k·S.
  - done pulses at cycle t+k·S+1.
  - For iters = 0, done pulses at t+1 and busy never rises.
- Back-to-back runs: start may be accepted at the earliest in the cycle after the done pulse (IDLE).
- Output timing: rd_data reflects the registered state; during RUN it shows intermediate stage values.

Test Plan:
- Reset: release rst_n, then sweep rd_lane over 0..7 -> rd_data = 0,1,…,7 (W=32, N=8).
- Zero iterations: iters=0, start=1 -> done high exactly one cycle later, busy stays 0, all lanes unchanged.
- Known answer: W=8, N=4, ROUNDS=0; load all lanes 0; start with iters=1 -> busy for 5 cycles, done on the 6th cycle, final lanes = 21, 6, 2, 84.
- Timing and ignored inputs: defaults, iters=3; start → busy high for exactly 33 cycles. Pulse start and load mid-run -> both ignored, run length unchanged, final state matches the reference-model result computed without those pulses.
- Reset mid-run: assert rst_n=0 at stage 4 of block 2 -> next cycle busy=0, done never pulses, lanes = i. A subsequent normal run gives the same result as a run started from a fresh reset.
- Simultaneous events: load(lane 2, 0xDEADBEEF) together with start, iters=1 -> the result equals the model output for a seed of x = [0,1,0xDEADBEEF,3,4,5,6,7].
